// File: rtl/fire_writer_pkg.sv
// Shared types and sizing helpers for the fire-layer ofm writer.
package fire_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    function automatic int addr_w(input int dsp_no, input int wout);
        return $clog2(dsp_no * wout * wout);
    endfunction

endpackage

// File: rtl/ofm_shadow_buf.sv
// Shadow copy of the ofm vector being drained, plus an optional one-entry
// pending vector when FIRE_OFM_WRITER_SKID_EN is defined.
module ofm_shadow_buf #(
    parameter int DSP_NO = 128,
    parameter int WIDTH  = 16,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             pend_full
);

    logic [WIDTH-1:0] shadow [0:DSP_NO-1];

`ifdef FIRE_OFM_WRITER_SKID_EN
    logic [WIDTH-1:0] pend [0:DSP_NO-1];

    always_ff @(posedge clk) begin
        if (load)
            shadow <= ofm;
        else if (pop)
            shadow <= pend;
        if (push)
            pend <= ofm;
    end

    // push wins over pop so a sample arriving while the entry drains refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend_full <= 1'b0;
        else if (push)
            pend_full <= 1'b1;
        else if (pop)
            pend_full <= 1'b0;
    end

    assign rd_data = load ? ofm[rd_idx] : (pop ? pend[rd_idx] : shadow[rd_idx]);
`else
    logic unused_skid;

    always_ff @(posedge clk) begin
        if (load)
            shadow <= ofm;
    end

    assign pend_full   = 1'b0;
    assign unused_skid = push | pop;
    assign rd_data     = load ? ofm[rd_idx] : shadow[rd_idx];
`endif

endmodule

// File: rtl/fire_ofm_writer.sv
// Serialises each captured ofm vector onto one RAM write port, channel-major.
// Optional pending-sample skid buffer: FIRE_OFM_WRITER_SKID_EN.
module fire_ofm_writer
    import fire_writer_pkg::*;
#(
    parameter int WOUT   = 128,
    parameter int DSP_NO = 128,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = addr_w(DSP_NO, WOUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_sample,
    input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_feedback,
    output logic              busy,
    output logic              overflow
);

    localparam int PIX_N = WOUT * WOUT;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX_N - 1);
    localparam logic [ADDR_W-1:0] PLANE    = ADDR_W'(PIX_N);

    wr_state_e        state, state_n;
    logic [CH_W-1:0]  ch, ch_n;
    logic [PIX_W-1:0] pix, pix_n;
    logic             load, push, pop, ovf_set, we_n, pend_full;
    logic [WIDTH-1:0] rd_data;

    ofm_shadow_buf #(
        .DSP_NO(DSP_NO),
        .WIDTH (WIDTH),
        .IDX_W (CH_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .push     (push),
        .pop      (pop),
        .ofm      (ofm),
        .rd_idx   (ch_n),
        .rd_data  (rd_data),
        .pend_full(pend_full)
    );

    // ch/pix name the write that will be on the bus next cycle
    always_comb begin
        state_n = state;
        ch_n    = ch;
        pix_n   = pix;
        load    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        we_n    = 1'b0;
        case (state)
            IDLE: begin
                if (layer_sample) begin
                    load    = 1'b1;
                    ch_n    = '0;
                    we_n    = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (ch == CH_LAST) begin
                    ch_n = '0;
                    if (pix == PIX_LAST) begin
                        state_n = DONE;
                    end else begin
                        pix_n = pix + 1'b1;
                        if (pend_full) begin
                            pop  = 1'b1;
                            push = layer_sample;
                            we_n = 1'b1;
                        end else if (layer_sample) begin
                            load = 1'b1;
                            we_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end else begin
                    ch_n = ch + 1'b1;
                    we_n = 1'b1;
                    if (layer_sample) begin
`ifdef FIRE_OFM_WRITER_SKID_EN
                        if (pend_full)
                            ovf_set = 1'b1;
                        else
                            push = 1'b1;
`else
                        ovf_set = 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            pix       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            overflow  <= 1'b0;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            pix      <= pix_n;
            ram_we   <= we_n;
            overflow <= overflow | ovf_set;
            if (we_n) begin
                ram_addr  <= ADDR_W'(ch_n) * PLANE + ADDR_W'(pix_n);
                ram_wdata <= rd_data;
            end
        end
    end

    assign busy         = (state == DRAIN);
    assign ram_feedback = (state == DONE);

endmodule

// File: tb/tb_fire_ofm_writer.sv
// Bench for fire_ofm_writer at WOUT=2, DSP_NO=4: directed scenarios plus a
// randomized run against a pixel-schedule reference model.
module tb_fire_ofm_writer;

    localparam int WOUT   = 2;
    localparam int DSP_NO = 4;
    localparam int WIDTH  = 16;
    localparam int PIX_N  = WOUT * WOUT;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              layer_sample = 1'b0;
    logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_feedback, busy, overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fire_ofm_writer #(
        .WOUT  (WOUT),
        .DSP_NO(DSP_NO),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .layer_sample(layer_sample),
        .ofm         (ofm),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_feedback(ram_feedback),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic do_reset();
        layer_sample = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_ofm();
        for (int c = 0; c < DSP_NO; c++) ofm[c] = WIDTH'($urandom);
    endtask

    task automatic test_reset();
        for (int c = 0; c < DSP_NO; c++) ofm[c] = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_feedback, busy, overflow} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: we/fb/busy/ovf=%b expected 0000", {ram_we, ram_feedback, busy, overflow});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0) begin
            failures++;
            $display("FAIL reset_bus: addr=%0d data=%0d expected 0/0", ram_addr, ram_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: we=%b busy=%b expected 0/0", ram_we, busy);
        end
    endtask

    task automatic test_single_pixel();
        do_reset();
        for (int c = 0; c < DSP_NO; c++) ofm[c] = WIDTH'(c + 1);
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        for (int c = 0; c < DSP_NO; c++) begin
            checks++;
            if (ram_we !== 1'b1 || busy !== 1'b1 || ram_addr !== ADDR_W'(c * PIX_N) || ram_wdata !== WIDTH'(c + 1)) begin
                failures++;
                $display("FAIL single_write[%0d]: we=%b busy=%b addr=%0d data=%0d expected 1/1/%0d/%0d",
                         c, ram_we, busy, ram_addr, ram_wdata, c * PIX_N, c + 1);
            end
            @(negedge clk);
        end
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: we=%b busy=%b expected 0/0", ram_we, busy);
        end
    endtask

    task automatic test_full_layer();
        logic [WIDTH-1:0] vec [0:PIX_N-1][0:DSP_NO-1];
        logic [WIDTH-1:0] got [0:DSP_NO*PIX_N-1];
        int seen [0:DSP_NO*PIX_N-1];
        int nwr, last_wr, fb_cyc, a;
        nwr = 0; last_wr = -1; fb_cyc = -1;
        for (int i = 0; i < DSP_NO * PIX_N; i++) begin seen[i] = 0; got[i] = '0; end
        for (int p = 0; p < PIX_N; p++)
            for (int c = 0; c < DSP_NO; c++) vec[p][c] = WIDTH'($urandom);
        do_reset();
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc % 10 == 0 && cyc < 10 * PIX_N) begin
                for (int c = 0; c < DSP_NO; c++) ofm[c] = vec[cyc / 10][c];
                layer_sample = 1'b1;
            end else begin
                layer_sample = 1'b0;
            end
            @(negedge clk);
            if (ram_we === 1'b1) begin
                a = int'(ram_addr);
                seen[a]++;
                got[a] = ram_wdata;
                nwr++;
                last_wr = cyc;
            end
            if (ram_feedback === 1'b1 && fb_cyc < 0) fb_cyc = cyc;
        end
        checks++;
        if (nwr != DSP_NO * PIX_N) begin
            failures++;
            $display("FAIL full_count: writes=%0d expected %0d", nwr, DSP_NO * PIX_N);
        end
        for (int i = 0; i < DSP_NO * PIX_N; i++) begin
            checks++;
            if (seen[i] != 1 || got[i] !== vec[i % PIX_N][i / PIX_N]) begin
                failures++;
                $display("FAIL full_addr[%0d]: hits=%0d data=%0d expected 1 hit data=%0d",
                         i, seen[i], got[i], vec[i % PIX_N][i / PIX_N]);
            end
        end
        checks++;
        if (fb_cyc != last_wr + 1) begin
            failures++;
            $display("FAIL full_feedback_time: fb_cycle=%0d expected %0d", fb_cyc, last_wr + 1);
        end
        rand_ofm();
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ram_we !== 1'b0 || overflow !== 1'b0 || ram_feedback !== 1'b1) begin
                failures++;
                $display("FAIL full_trailing[%0d]: we=%b ovf=%b fb=%b expected 0/0/1", k, ram_we, overflow, ram_feedback);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [0:DSP_NO-1];
        logic [WIDTH-1:0] vb [0:DSP_NO-1];
        for (int c = 0; c < DSP_NO; c++) begin va[c] = WIDTH'($urandom); vb[c] = WIDTH'($urandom); end
        do_reset();
        for (int c = 0; c < DSP_NO; c++) ofm[c] = va[c];
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        repeat (DSP_NO - 1) @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== ADDR_W'((DSP_NO - 1) * PIX_N) || ram_wdata !== va[DSP_NO-1]) begin
            failures++;
            $display("FAIL b2b_last_ch: we=%b addr=%0d data=%0d expected 1/%0d/%0d",
                     ram_we, ram_addr, ram_wdata, (DSP_NO - 1) * PIX_N, va[DSP_NO-1]);
        end
        for (int c = 0; c < DSP_NO; c++) ofm[c] = vb[c];
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        for (int c = 0; c < DSP_NO; c++) begin
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(c * PIX_N + 1) || ram_wdata !== vb[c]) begin
                failures++;
                $display("FAIL b2b_write[%0d]: we=%b addr=%0d data=%0d expected 1/%0d/%0d",
                         c, ram_we, ram_addr, ram_wdata, c * PIX_N + 1, vb[c]);
            end
            @(negedge clk);
        end
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: we=%b busy=%b expected 0/0", ram_we, busy);
        end
    endtask

    task automatic test_skid();
        logic [WIDTH-1:0] vb [0:DSP_NO-1];
        int wp [0:PIX_N-1];
        int exp_ovf_early, exp_p1, exp_p0;
`ifdef FIRE_OFM_WRITER_SKID_EN
        exp_ovf_early = 0; exp_p1 = DSP_NO;
`else
        exp_ovf_early = 1; exp_p1 = 0;
`endif
        exp_p0 = DSP_NO - 2;
        for (int p = 0; p < PIX_N; p++) wp[p] = 0;
        do_reset();
        rand_ofm();
        layer_sample = 1'b1;
        @(negedge clk);
        rand_ofm();
        for (int c = 0; c < DSP_NO; c++) vb[c] = ofm[c];
        @(negedge clk);
        checks++;
        if (overflow !== 1'(exp_ovf_early)) begin
            failures++;
            $display("FAIL skid_ovf_early: ovf=%b expected %0d", overflow, exp_ovf_early);
        end
        rand_ofm();
        @(negedge clk);
        layer_sample = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL skid_ovf: ovf=%b expected 1", overflow);
        end
        for (int k = 0; k < 10; k++) begin
            if (ram_we === 1'b1) begin
                wp[int'(ram_addr) % PIX_N]++;
                if (int'(ram_addr) % PIX_N == 1) begin
                    checks++;
                    if (ram_wdata !== vb[int'(ram_addr) / PIX_N]) begin
                        failures++;
                        $display("FAIL skid_pend_data: addr=%0d data=%0d expected %0d",
                                 ram_addr, ram_wdata, vb[int'(ram_addr) / PIX_N]);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (wp[0] != exp_p0 || wp[1] != exp_p1 || wp[2] != 0) begin
            failures++;
            $display("FAIL skid_writes: pix0=%0d pix1=%0d pix2=%0d expected %0d/%0d/0",
                     wp[0], wp[1], wp[2], exp_p0, exp_p1);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [WIDTH-1:0] vb [0:DSP_NO-1];
        do_reset();
        rand_ofm();
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(2 * PIX_N)) begin
            failures++;
            $display("FAIL rstmid_pre: we=%b addr=%0d expected 1/%0d", ram_we, ram_addr, 2 * PIX_N);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_feedback, busy, overflow} !== 4'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            failures++;
            $display("FAIL rstmid_clear: we/fb/busy/ovf=%b addr=%0d data=%0d expected all 0",
                     {ram_we, ram_feedback, busy, overflow}, ram_addr, ram_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_nowrite: we=%b expected 0", ram_we);
        end
        rand_ofm();
        for (int c = 0; c < DSP_NO; c++) vb[c] = ofm[c];
        layer_sample = 1'b1;
        @(negedge clk);
        layer_sample = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== '0 || ram_wdata !== vb[0]) begin
            failures++;
            $display("FAIL rstmid_restart: we=%b addr=%0d data=%0d expected 1/0/%0d", ram_we, ram_addr, ram_wdata, vb[0]);
        end
    endtask

    // Model: each accepted sample becomes pixel k (arrival order) occupying
    // DSP_NO consecutive bus cycles from its start cycle.
    task automatic test_random();
        int start_c [0:PIX_N-1];
        logic [WIDTH-1:0] mdat [0:PIX_N-1][0:DSP_NO-1];
        int nacc, ovf_cyc, pct, last_end, off;
        logic exp_we, exp_fb, exp_ovf, fire, acc, done_ok;
        logic [ADDR_W-1:0] exp_addr, last_addr;
        logic [WIDTH-1:0] exp_data, last_data;
        for (int run = 0; run < 30; run++) begin
            do_reset();
            nacc = 0; ovf_cyc = -1; pct = $urandom_range(3, 60);
            last_addr = '0; last_data = '0;
            for (int n = 0; n < 160; n++) begin
                exp_we = 1'b0; exp_addr = last_addr; exp_data = last_data;
                for (int k = 0; k < nacc; k++) begin
                    if (n >= start_c[k] && n < start_c[k] + DSP_NO) begin
                        off = n - start_c[k];
                        exp_we = 1'b1;
                        exp_addr = ADDR_W'(off * PIX_N + k);
                        exp_data = mdat[k][off];
                    end
                end
                exp_fb  = (nacc == PIX_N) && (n >= start_c[PIX_N-1] + DSP_NO);
                exp_ovf = (ovf_cyc >= 0) && (n >= ovf_cyc);
                checks++;
                if (ram_we !== exp_we || busy !== exp_we || ram_feedback !== exp_fb || overflow !== exp_ovf) begin
                    failures++;
                    $display("FAIL rnd_ctrl run%0d cyc%0d: we/busy/fb/ovf=%b%b%b%b expected %b%b%b%b",
                             run, n, ram_we, busy, ram_feedback, overflow, exp_we, exp_we, exp_fb, exp_ovf);
                end
                checks++;
                if (ram_addr !== exp_addr || ram_wdata !== exp_data) begin
                    failures++;
                    $display("FAIL rnd_data run%0d cyc%0d: addr=%0d data=%0d expected %0d/%0d",
                             run, n, ram_addr, ram_wdata, exp_addr, exp_data);
                end
                last_addr = exp_addr; last_data = exp_data;
                done_ok = (nacc == PIX_N) && (n >= start_c[PIX_N-1] + DSP_NO - 1);
                if (nacc < PIX_N)  fire = ($urandom_range(0, 99) < pct);
                else if (done_ok)  fire = ($urandom_range(0, 99) < 20);
                else               fire = 1'b0;
                rand_ofm();
                layer_sample = fire;
                if (fire && nacc < PIX_N) begin
                    last_end = (nacc > 0) ? start_c[nacc-1] + DSP_NO - 1 : -1;
`ifdef FIRE_OFM_WRITER_SKID_EN
                    acc = !(nacc > 0 && start_c[nacc-1] > n + 1);
`else
                    acc = !(nacc > 0 && n >= start_c[nacc-1] && n < last_end);
`endif
                    if (acc) begin
                        start_c[nacc] = (n + 1 > last_end + 1) ? n + 1 : last_end + 1;
                        for (int c = 0; c < DSP_NO; c++) mdat[nacc][c] = ofm[c];
                        nacc++;
                    end else if (ovf_cyc < 0) begin
                        ovf_cyc = n + 1;
                    end
                end
                @(negedge clk);
            end
            layer_sample = 1'b0;
        end
    endtask

    initial begin
        for (int c = 0; c < DSP_NO; c++) ofm[c] = '0;
        test_reset();
        test_single_pixel();
        test_full_layer();
        test_back_to_back();
        test_skid();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
